// File: rtl/multi_rate_divider.sv
// Multi-channel programmable clock-enable divider with shadowed configuration.
// Each channel counts 0..D, ticks at D, and drives high while its count is below H.
module multi_rate_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CH_BITS  = 2
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic [CHANNELS-1:0] i_Enable,
  input  logic                i_Sync,
  input  logic                i_Wr_En,
  input  logic [CH_BITS-1:0]  i_Wr_Chan,
  input  logic [WIDTH-1:0]    i_Wr_Div,
  input  logic [WIDTH-1:0]    i_Wr_High,
  output logic [CHANNELS-1:0] o_Tick,
  output logic [CHANNELS-1:0] o_Out,
  output logic [CHANNELS-1:0] o_Pending
);

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(3);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(2);

  logic [WIDTH-1:0]    cnt   [CHANNELS];
  logic [WIDTH-1:0]    act_d [CHANNELS];
  logic [WIDTH-1:0]    act_h [CHANNELS];
  logic [WIDTH-1:0]    sh_d  [CHANNELS];
  logic [WIDTH-1:0]    sh_h  [CHANNELS];
  logic [CHANNELS-1:0] pend;

  logic                wr_valid;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] apply;

  // Writes addressing a channel beyond CHANNELS are dropped.
  assign wr_valid  = i_Wr_En && ({1'b0, i_Wr_Chan} < (CH_BITS+1)'(CHANNELS));
  assign o_Pending = pend;

  always_comb begin
    wr_hit = '0;
    wrap   = '0;
    apply  = '0;
    o_Tick = '0;
    o_Out  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_valid && (i_Wr_Chan == CH_BITS'(i));
      wrap[i]   = i_Enable[i] && (cnt[i] == act_d[i]);
      // Shadow lands at the period boundary, on sync, or at once when idle.
      apply[i]  = pend[i] && (i_Sync || !i_Enable[i] || wrap[i]);
      o_Tick[i] = wrap[i];
      o_Out[i]  = i_Enable[i] && (cnt[i] < act_h[i]);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      pend <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i]   <= '0;
        act_d[i] <= DEF_D;
        act_h[i] <= DEF_H;
        sh_d[i]  <= DEF_D;
        sh_h[i]  <= DEF_H;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (i_Sync || !i_Enable[i] || wrap[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + WIDTH'(1);

        if (apply[i]) begin
          act_d[i] <= sh_d[i];
          act_h[i] <= sh_h[i];
        end

        // A write coinciding with an apply: old shadow goes active, new one stays pending.
        if (wr_hit[i]) begin
          sh_d[i] <= i_Wr_Div;
          sh_h[i] <= i_Wr_High;
          pend[i] <= 1'b1;
        end else if (apply[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed self-checking bench for multi_rate_divider (4 channels, 8-bit, 3-bit channel select).
module tb_multi_rate_divider;

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic [3:0] i_Enable;
  logic       i_Sync;
  logic       i_Wr_En;
  logic [2:0] i_Wr_Chan;
  logic [7:0] i_Wr_Div;
  logic [7:0] i_Wr_High;
  logic [3:0] o_Tick;
  logic [3:0] o_Out;
  logic [3:0] o_Pending;

  int n_cmp = 0;
  int n_err = 0;

  multi_rate_divider #(.CHANNELS(4), .WIDTH(8), .CH_BITS(3)) dut (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Enable  (i_Enable),
    .i_Sync    (i_Sync),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Chan (i_Wr_Chan),
    .i_Wr_Div  (i_Wr_Div),
    .i_Wr_High (i_Wr_High),
    .o_Tick    (o_Tick),
    .o_Out     (o_Out),
    .o_Pending (o_Pending)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_Clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d, input logic [7:0] h);
    i_Wr_En   = 1'b1;
    i_Wr_Chan = ch;
    i_Wr_Div  = d;
    i_Wr_High = h;
  endtask

  initial begin
    i_Reset = 1'b0; i_Enable = '0; i_Sync = 1'b0;
    i_Wr_En = 1'b0; i_Wr_Chan = '0; i_Wr_Div = '0; i_Wr_High = '0;
    cyc(); cyc();
    chk("rst_tick", 8'(o_Tick), 8'h0);
    chk("rst_out", 8'(o_Out), 8'h0);
    chk("rst_pend", 8'(o_Pending), 8'h0);
    i_Reset = 1'b1;
    cyc();

    // Channel 0 default divide-by-4
    i_Enable = 4'b0001;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("ch0_out", 8'(o_Out[0]), 8'((k % 4) < 2));
      chk("ch0_tick", 8'(o_Tick[0]), 8'((k % 4) == 3));
      cyc();
    end

    // Channel 1 reconfigured mid-period; change lands at the C==3 wrap
    i_Enable = 4'b0011;
    cyc();
    wr(3'd1, 8'd5, 8'd1);
    #1;
    chk("ch1_pend_before", 8'(o_Pending[1]), 8'h0);
    cyc();
    i_Wr_En = 1'b0;
    chk("ch1_pend_c2", 8'(o_Pending[1]), 8'h1);
    chk("ch1_out_c2", 8'(o_Out[1]), 8'h0);
    cyc();
    chk("ch1_pend_c3", 8'(o_Pending[1]), 8'h1);
    chk("ch1_tick_c3", 8'(o_Tick[1]), 8'h1);
    cyc();
    chk("ch1_pend_after", 8'(o_Pending[1]), 8'h0);
    for (int k = 0; k < 12; k++) begin
      chk("ch1_out6", 8'(o_Out[1]), 8'((k % 6) < 1));
      chk("ch1_tick6", 8'(o_Tick[1]), 8'((k % 6) == 5));
      cyc();
    end

    // Channel 2 configured while disabled: D=0, H=0
    wr(3'd2, 8'd0, 8'd0);
    cyc();
    i_Wr_En = 1'b0;
    chk("ch2_pend_set", 8'(o_Pending[2]), 8'h1);
    cyc();
    chk("ch2_pend_idle_apply", 8'(o_Pending[2]), 8'h0);
    i_Enable = 4'b0111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("ch2_tick_const", 8'(o_Tick[2]), 8'h1);
      chk("ch2_out_const", 8'(o_Out[2]), 8'h0);
      cyc();
    end

    // Out-of-range channel write is ignored
    wr(3'd4, 8'd9, 8'd9);
    cyc();
    i_Wr_En = 1'b0;
    chk("oob_pend", 8'(o_Pending), 8'h0);

    // Channels 0 and 3 out of phase, then sync aligns them (ch0 C=3 here)
    i_Enable = 4'b1111;
    #1;
    chk("phase_tick0", 8'(o_Tick[0]), 8'h1);
    chk("phase_tick3", 8'(o_Tick[3]), 8'h0);
    cyc();
    cyc();
    i_Sync = 1'b1;
    cyc();
    i_Sync = 1'b0;
    chk("sync_out1", 8'(o_Out[1]), 8'h1);
    for (int k = 0; k < 8; k++) begin
      chk("sync_tick0", 8'(o_Tick[0]), 8'(k % 4 == 3));
      chk("sync_tick3", 8'(o_Tick[3]), 8'(k % 4 == 3));
      chk("sync_out3", 8'(o_Out[3]), 8'(k % 4 < 2));
      cyc();
    end

    // Channel 3: shadow A pending, shadow B written on the wrap cycle
    wr(3'd3, 8'd2, 8'd1);
    cyc();
    i_Wr_En = 1'b0;
    cyc();
    cyc();
    chk("ch3_wrap_tick", 8'(o_Tick[3]), 8'h1);
    wr(3'd3, 8'd4, 8'd3);
    cyc();
    i_Wr_En = 1'b0;
    chk("ch3_pend_kept", 8'(o_Pending[3]), 8'h1);
    chk("ch3_a_out0", 8'(o_Out[3]), 8'h1);
    cyc();
    chk("ch3_a_out1", 8'(o_Out[3]), 8'h0);
    chk("ch3_a_tick1", 8'(o_Tick[3]), 8'h0);
    cyc();
    chk("ch3_a_tick2", 8'(o_Tick[3]), 8'h1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("ch3_b_pend", 8'(o_Pending[3]), 8'h0);
      chk("ch3_b_out", 8'(o_Out[3]), 8'(k < 3));
      chk("ch3_b_tick", 8'(o_Tick[3]), 8'(k == 4));
      cyc();
    end

    // Sync applies a pending shadow mid-period
    wr(3'd3, 8'd1, 8'd1);
    cyc();
    i_Wr_En = 1'b0;
    i_Sync  = 1'b1;
    #1;
    chk("sync_apply_pend_before", 8'(o_Pending[3]), 8'h1);
    cyc();
    i_Sync = 1'b0;
    chk("sync_apply_pend_after", 8'(o_Pending[3]), 8'h0);
    chk("sync_apply_out0", 8'(o_Out[3]), 8'h1);
    chk("sync_apply_tick0", 8'(o_Tick[3]), 8'h0);
    cyc();
    chk("sync_apply_tick1", 8'(o_Tick[3]), 8'h1);
    chk("sync_apply_out1", 8'(o_Out[3]), 8'h0);
    cyc();
    chk("sync_apply_tick2", 8'(o_Tick[3]), 8'h0);

    // One-cycle reset mid-period discards a pending write
    wr(3'd1, 8'd7, 8'd7);
    cyc();
    i_Wr_En = 1'b0;
    chk("pre_reset_pend", 8'(o_Pending[1]), 8'h1);
    i_Reset = 1'b0;
    cyc();
    i_Reset = 1'b1;
    #1;
    chk("post_reset_pend", 8'(o_Pending), 8'h0);
    for (int k = 0; k < 8; k++) begin
      chk("post_reset_out", 8'(o_Out), (k % 4 < 2) ? 8'h0f : 8'h00);
      chk("post_reset_tick", 8'(o_Tick), (k % 4 == 3) ? 8'h0f : 8'h00);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
